intadd_pipe: RTL

Pipelined, parametrised successor to the combinational SIMD integer adder. It accepts one packed add instruction per cycle over a valid/ready handshake. Each instruction adds lanes of 4+8, 8, 16 or 32 bits with per-operand signedness, and returns packed results plus per-lane overflow flags after a configurable register latency. It sits between the vector register-file read stage and writeback, and supports backpressure from writeback.

---
 rtl/intadd_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/intadd_pipe.sv
// Pipelined SIMD integer adder (MIX4_8 / ADD8 / ADD16 / ADD32) with valid/ready handshake.
// Define INTADD_SAT_EN to honour the sat input (clamp on overflow); otherwise lanes always wrap.
module intadd_pipe #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LAT    = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic                  sign_s0,
  input  logic                  sign_s1,
  input  logic                  sat,
  input  logic [TAG_W-1:0]      tag,
  input  logic [DATA_W-1:0]     src_reg0,
  input  logic [DATA_W-1:0]     src_reg1,
  input  logic [DATA_W-1:0]     src_reg2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     dst_reg0,
  output logic [DATA_W-1:0]     dst_reg1,
  output logic [DATA_W/4-1:0]   ovf,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned NL = DATA_W / 4;

  // One lane: extend A (aw bits) and B (bw bits) into a 34-bit exact sum,
  // range-check against the w-bit result type; returns {ovf, result}.
  function automatic logic [32:0] lane_add(
    input logic [31:0] a, input int unsigned aw,
    input logic [31:0] b, input int unsigned bw,
    input int unsigned w, input logic sa, input logic sb, input logic st);
    logic [33:0]        am, bm, rm, ae, be;
    logic signed [33:0] s, hi, lo;
    logic               rs, o;
    logic [31:0]        r;
    am = (34'd1 << aw) - 34'd1;
    bm = (34'd1 << bw) - 34'd1;
    rm = (34'd1 << w) - 34'd1;
    ae = {2'b00, a} & am;
    if (sa && a[aw-1]) ae = ae | ~am;
    be = {2'b00, b} & bm;
    if (sb && b[bw-1]) be = be | ~bm;
    s  = signed'(ae + be);
    rs = sa | sb;
    hi = rs ? signed'((34'd1 << (w - 1)) - 34'd1) : signed'(rm);
    lo = rs ? signed'(~((34'd1 << (w - 1)) - 34'd1)) : '0;
    o  = (s > hi) || (s < lo);
    r  = s[31:0] & rm[31:0];
    if (st && o) r = (s < lo) ? (lo[31:0] & rm[31:0]) : (hi[31:0] & rm[31:0]);
    return {o, r};
  endfunction

  logic                sat_eff;
  logic [DATA_W-1:0]   d0_d, d1_d;
  logic [NL-1:0]       ovf_d;
  logic [32:0]         r;
  logic [31:0]         la, lb;
  int unsigned         w;

`ifdef INTADD_SAT_EN
  assign sat_eff = sat;
`else
  assign sat_eff = sat & 1'b0;
`endif

  always_comb begin
    d0_d  = '0;
    d1_d  = '0;
    ovf_d = '0;
    r     = '0;
    la    = '0;
    lb    = '0;
    w     = 32'd4 << mode;
    if (mode == 2'b00) begin
      for (int unsigned i = 0; i < NL; i++) begin
        la = {28'd0, 4'(src_reg0 >> (4 * i))};
        lb = {24'd0, 4'(src_reg2 >> (4 * i)), 4'(src_reg1 >> (4 * i))};
        r  = lane_add(la, 4, lb, 8, 8, sign_s0, sign_s1, sat_eff);
        if (i < DATA_W / 8) d0_d[8*i +: 8] = r[7:0];
        else                d1_d[8*(i - DATA_W/8) +: 8] = r[7:0];
        ovf_d[i] = r[32];
      end
    end else begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (i < DATA_W / w) begin
          la = 32'(src_reg0 >> (w * i));
          lb = 32'(src_reg1 >> (w * i));
          r  = lane_add(la, w, lb, w, w, sign_s0, sign_s1, sat_eff);
          d0_d = d0_d | (DATA_W'(r[31:0]) << (w * i));
          ovf_d[i] = r[32];
        end
      end
    end
  end

  logic [LAT-1:0]    v_q;
  logic [DATA_W-1:0] d0_q  [LAT];
  logic [DATA_W-1:0] d1_q  [LAT];
  logic [NL-1:0]     ovf_q [LAT];
  logic [TAG_W-1:0]  tag_q [LAT];
  logic [LAT-1:0]    load;
  logic              accept;

  // Stage k may load unless it and every stage after it is full while the output stalls;
  // written in closed form so no bit of load depends on another.
  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < LAT; k++)
      load[k] = out_ready || !(&(v_q | LAT'((32'd1 << k) - 32'd1)));
  end

  assign in_ready = rst_n && load[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        d0_q[k]  <= '0;
        d1_q[k]  <= '0;
        ovf_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        v_q[0]   <= accept;
        d0_q[0]  <= d0_d;
        d1_q[0]  <= d1_d;
        ovf_q[0] <= ovf_d;
        tag_q[0] <= tag;
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        if (load[k]) begin
          v_q[k]   <= v_q[k-1];
          d0_q[k]  <= d0_q[k-1];
          d1_q[k]  <= d1_q[k-1];
          ovf_q[k] <= ovf_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign dst_reg0  = d0_q[LAT-1];
  assign dst_reg1  = d1_q[LAT-1];
  assign ovf       = ovf_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];

endmodule
